// File: rtl/key_event_decode_pkg.sv
// Shared definitions for the per-key gesture classifier.
package key_event_decode_pkg;

    // Default timing at a 50 MHz system clock.
    localparam int unsigned KEY_LONG_CYC_DEF = 50_000_000; // 1 s hold
    localparam int unsigned KEY_GAP_CYC_DEF  = 15_000_000; // 300 ms double-click window
    localparam int unsigned KEY_REP_CYC_DEF  = 10_000_000; // 200 ms auto-repeat
    localparam int unsigned KEY_CNT_W_DEF    = 26;

    // Gesture FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } key_state_e;

    // Debounced edge decode: key_state is 0 on a press edge, 1 on a release edge.
    function automatic logic is_press(input logic flag, input logic state);
        return flag & ~state;
    endfunction

    function automatic logic is_release(input logic flag, input logic state);
        return flag & state;
    endfunction

endpackage

// File: rtl/key_event_decode.sv
// Per-key gesture classifier: short press, double click, long press and
// auto-repeat pulses from debounced press/release edges.
module key_event_decode
    import key_event_decode_pkg::*;
#(
    parameter int unsigned LONG_CYC = KEY_LONG_CYC_DEF,
    parameter int unsigned GAP_CYC  = KEY_GAP_CYC_DEF,
    parameter int unsigned REP_CYC  = KEY_REP_CYC_DEF,
    parameter int unsigned CNT_W    = KEY_CNT_W_DEF
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic key_flag,
    input  logic key_state,
    output logic pressed,
    output logic short_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

    key_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pressed_q;
    logic             short_q;
    logic             double_q;
    logic             long_q;
    logic             repeat_q;

    logic press_c;
    logic release_c;

    assign press_c   = is_press(key_flag, key_state);
    assign release_c = is_release(key_flag, key_state);

    // Gesture FSM with its cycle counter; every state change clears the counter
    // and every terminal count forces a change or clear, so it never wraps.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            short_q   <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (press_c) begin
                        state_q   <= ST_PRESS1;
                        cnt_q     <= '0;
                        pressed_q <= 1'b1;
                    end
                end
                ST_PRESS1: begin
                    // A release on the terminal cycle beats long detection.
                    if (release_c) begin
                        state_q   <= ST_WAIT2;
                        cnt_q     <= '0;
                        pressed_q <= 1'b0;
                    end else if (cnt_q == LONG_LAST) begin
                        state_q <= ST_LONG;
                        cnt_q   <= '0;
                        long_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT2: begin
                    // A press on the terminal cycle still forms a double click.
                    if (press_c) begin
                        state_q   <= ST_PRESS2;
                        cnt_q     <= '0;
                        pressed_q <= 1'b1;
                    end else if (cnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        short_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_PRESS2: begin
                    if (release_c) begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        pressed_q <= 1'b0;
                        double_q  <= 1'b1;
                    end
                end
                ST_LONG: begin
                    // Release suppresses a same-cycle repeat.
                    if (release_c) begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        pressed_q <= 1'b0;
                    end else if (cnt_q == REP_LAST) begin
                        cnt_q    <= '0;
                        repeat_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    pressed_q <= 1'b0;
                end
            endcase
        end
    end

    assign pressed      = pressed_q;
    assign short_pulse  = short_q;
    assign double_pulse = double_q;
    assign long_pulse   = long_q;
    assign repeat_pulse = repeat_q;

endmodule

// File: tb/tb_key_event_decode.sv
// Scoreboard bench for key_event_decode with short timing parameters.
module tb_key_event_decode;

    localparam int unsigned LONG_CYC = 20;
    localparam int unsigned GAP_CYC  = 8;
    localparam int unsigned REP_CYC  = 5;
    localparam int unsigned CNT_W    = 26;

    // Pulse codes: 0 none, 1 short, 2 double, 3 long, 4 repeat, 7 several at once.
    localparam logic [2:0] P_NONE = 3'd0;
    localparam logic [2:0] P_SHORT = 3'd1;
    localparam logic [2:0] P_DOUBLE = 3'd2;
    localparam logic [2:0] P_LONG = 3'd3;
    localparam logic [2:0] P_REPEAT = 3'd4;

    typedef struct {
        int         cyc;
        logic [2:0] code;
    } exp_t;

    typedef struct {
        int   cyc;
        logic st;
    } stim_t;

    logic clk;
    logic rst_n;
    logic key_flag;
    logic key_state;
    logic pressed;
    logic short_pulse;
    logic double_pulse;
    logic long_pulse;
    logic repeat_pulse;

    int checks = 0;
    int errors = 0;

    exp_t  exp_q[$];
    stim_t stim_q[$];

    key_event_decode #(
        .LONG_CYC(LONG_CYC),
        .GAP_CYC (GAP_CYC),
        .REP_CYC (REP_CYC),
        .CNT_W   (CNT_W)
    ) dut (
        .Clk         (clk),
        .Rst_n       (rst_n),
        .key_flag    (key_flag),
        .key_state   (key_state),
        .pressed     (pressed),
        .short_pulse (short_pulse),
        .double_pulse(double_pulse),
        .long_pulse  (long_pulse),
        .repeat_pulse(repeat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] pulse_code();
        int n;
        logic [2:0] c;
        n = 0;
        c = P_NONE;
        if (short_pulse)  begin n++; c = P_SHORT;  end
        if (double_pulse) begin n++; c = P_DOUBLE; end
        if (long_pulse)   begin n++; c = P_LONG;   end
        if (repeat_pulse) begin n++; c = P_REPEAT; end
        if (n > 1) c = 3'd7;
        return c;
    endfunction

    // Expected pulse for relative cycle c, popped from the scoreboard.
    function automatic logic [2:0] pop_exp(input int c);
        exp_t e;
        if (exp_q.size() != 0 && exp_q[0].cyc == c) begin
            e = exp_q.pop_front();
            return e.code;
        end
        return P_NONE;
    endfunction

    function automatic void push_exp(input int c, input logic [2:0] code);
        exp_t e;
        e.cyc = c;
        e.code = code;
        exp_q.push_back(e);
    endfunction

    function automatic void push_stim(input int c, input logic st);
        stim_t s;
        s.cyc = c;
        s.st = st;
        stim_q.push_back(s);
    endfunction

    // One cycle: drive this cycle's flag, sample registered outputs, advance.
    task automatic step(input int c, output logic [2:0] code, output logic pr);
        stim_t s;
        key_flag = 1'b0;
        key_state = 1'b0;
        if (stim_q.size() != 0 && stim_q[0].cyc == c) begin
            s = stim_q.pop_front();
            key_flag = 1'b1;
            key_state = s.st;
        end
        code = pulse_code();
        pr = pressed;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_flag = 1'b0;
        key_state = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pressed, short_pulse, double_pulse, long_pulse, repeat_pulse} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=00000",
                     {pressed, short_pulse, double_pulse, long_pulse, repeat_pulse});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_short();
        logic [2:0] obs, ex;
        logic pr, ep;
        exp_q.delete();
        push_stim(10, 1'b0);
        push_stim(15, 1'b1);
        push_exp(24, P_SHORT);
        for (int c = 0; c < 40; c++) begin
            step(c, obs, pr);
            ex = pop_exp(c);
            ep = (c >= 11 && c <= 15);
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL short_pulse cyc=%0d got=%0d want=%0d", c, obs, ex);
            end
            checks++;
            if (pr !== ep) begin
                errors++;
                $display("FAIL short_pressed cyc=%0d got=%b want=%b", c, pr, ep);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL short_missing got=%0d want=0 pending", exp_q.size());
        end
    endtask

    task automatic test_double();
        logic [2:0] obs, ex;
        logic pr, ep;
        exp_q.delete();
        push_stim(10, 1'b0);
        push_stim(14, 1'b1);
        push_stim(18, 1'b0);
        push_stim(22, 1'b1);
        push_exp(23, P_DOUBLE);
        for (int c = 0; c < 40; c++) begin
            step(c, obs, pr);
            ex = pop_exp(c);
            ep = (c >= 11 && c <= 14) || (c >= 19 && c <= 22);
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL double_pulse cyc=%0d got=%0d want=%0d", c, obs, ex);
            end
            checks++;
            if (pr !== ep) begin
                errors++;
                $display("FAIL double_pressed cyc=%0d got=%b want=%b", c, pr, ep);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL double_missing got=%0d want=0 pending", exp_q.size());
        end
    endtask

    // Release at 50 lands on a repeat terminal cycle (LONG entered at 31).
    task automatic test_long_repeat();
        logic [2:0] obs, ex;
        logic pr, ep;
        exp_q.delete();
        push_stim(10, 1'b0);
        push_stim(50, 1'b1);
        push_exp(31, P_LONG);
        push_exp(36, P_REPEAT);
        push_exp(41, P_REPEAT);
        push_exp(46, P_REPEAT);
        for (int c = 0; c < 70; c++) begin
            step(c, obs, pr);
            ex = pop_exp(c);
            ep = (c >= 11 && c <= 50);
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL long_pulse cyc=%0d got=%0d want=%0d", c, obs, ex);
            end
            checks++;
            if (pr !== ep) begin
                errors++;
                $display("FAIL long_pressed cyc=%0d got=%b want=%b", c, pr, ep);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL long_missing got=%0d want=0 pending", exp_q.size());
        end
    endtask

    // Releases one cycle before and exactly on the PRESS1 terminal cycle (30).
    task automatic test_release_terminal();
        logic [2:0] obs, ex;
        logic pr, ep;
        for (int r = 29; r <= 30; r++) begin
            exp_q.delete();
            push_stim(10, 1'b0);
            push_stim(r, 1'b1);
            push_exp(r + GAP_CYC + 1, P_SHORT);
            for (int c = 0; c < 55; c++) begin
                step(c, obs, pr);
                ex = pop_exp(c);
                ep = (c >= 11 && c <= r);
                checks++;
                if (obs !== ex) begin
                    errors++;
                    $display("FAIL rel_term_pulse rel=%0d cyc=%0d got=%0d want=%0d", r, c, obs, ex);
                end
                checks++;
                if (pr !== ep) begin
                    errors++;
                    $display("FAIL rel_term_pressed rel=%0d cyc=%0d got=%b want=%b", r, c, pr, ep);
                end
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL rel_term_missing got=%0d want=0 pending", exp_q.size());
            end
        end
    endtask

    // WAIT2 entered at 16, terminal cycle 23: a press there still counts.
    task automatic test_wait2_terminal();
        logic [2:0] obs, ex;
        logic pr, ep;
        exp_q.delete();
        push_stim(10, 1'b0);
        push_stim(15, 1'b1);
        push_stim(23, 1'b0);
        push_stim(27, 1'b1);
        push_exp(28, P_DOUBLE);
        for (int c = 0; c < 45; c++) begin
            step(c, obs, pr);
            ex = pop_exp(c);
            ep = (c >= 11 && c <= 15) || (c >= 24 && c <= 27);
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL wait2_term_pulse cyc=%0d got=%0d want=%0d", c, obs, ex);
            end
            checks++;
            if (pr !== ep) begin
                errors++;
                $display("FAIL wait2_term_pressed cyc=%0d got=%b want=%b", c, pr, ep);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wait2_term_missing got=%0d want=0 pending", exp_q.size());
        end
    endtask

    // Reset held for three cycles while in WAIT2 aborts the pending short press.
    task automatic test_reset_mid();
        logic [2:0] obs;
        logic pr, ep;
        exp_q.delete();
        push_stim(10, 1'b0);
        push_stim(15, 1'b1);
        for (int c = 0; c < 45; c++) begin
            if (c == 18) rst_n = 1'b0;
            if (c == 21) rst_n = 1'b1;
            step(c, obs, pr);
            ep = (c >= 11 && c <= 15);
            checks++;
            if (obs !== P_NONE) begin
                errors++;
                $display("FAIL reset_mid_pulse cyc=%0d got=%0d want=0", c, obs);
            end
            checks++;
            if (pr !== ep) begin
                errors++;
                $display("FAIL reset_mid_pressed cyc=%0d got=%b want=%b", c, pr, ep);
            end
        end
    endtask

    // Stray release in IDLE and a duplicate press in PRESS1 change nothing;
    // release at 40 coincides with a repeat terminal and wins.
    task automatic test_spurious();
        logic [2:0] obs, ex;
        logic pr, ep;
        exp_q.delete();
        push_stim(5, 1'b1);
        push_stim(10, 1'b0);
        push_stim(20, 1'b0);
        push_stim(40, 1'b1);
        push_exp(31, P_LONG);
        push_exp(36, P_REPEAT);
        for (int c = 0; c < 60; c++) begin
            step(c, obs, pr);
            ex = pop_exp(c);
            ep = (c >= 11 && c <= 40);
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL spurious_pulse cyc=%0d got=%0d want=%0d", c, obs, ex);
            end
            checks++;
            if (pr !== ep) begin
                errors++;
                $display("FAIL spurious_pressed cyc=%0d got=%b want=%b", c, pr, ep);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL spurious_missing got=%0d want=0 pending", exp_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        key_flag = 1'b0;
        key_state = 1'b0;
        #2;
        test_reset();
        test_short();
        test_double();
        test_long_repeat();
        test_release_terminal();
        test_wait2_terminal();
        test_reset_mid();
        test_spurious();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
